// File: rtl/uart_pkg.sv
// Shared UART types, frame-format limits and helpers used by the receive path
// (and the transmit path once it lands).
package uart_pkg;

    localparam int UART_MIN_DATA_WIDTH = 5;
    localparam int UART_MAX_DATA_WIDTH = 9;

    typedef enum logic [1:0] {
        UART_PARITY_NONE = 2'd0,
        UART_PARITY_ODD  = 2'd1,
        UART_PARITY_EVEN = 2'd2
    } uart_parity_e;

    typedef struct packed {
        logic [3:0]   data_bits;
        uart_parity_e parity_mode;
        logic         stop_bits;
    } uart_rx_cfg_t;

    typedef struct packed {
        logic brk;
        logic frame_err;
        logic parity_err;
    } uart_rx_err_t;

    // Narrower characters are passed zero-extended, so the unused upper bits
    // leave the reduction unchanged and one function serves every width.
    function automatic logic uart_parity(input logic [UART_MAX_DATA_WIDTH-1:0] data,
                                         input uart_parity_e                     mode);
        return (mode == UART_PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every divider_i clocks, held at
// zero while clear_i is high so the first tick is phase-aligned to its release.
module uart_baud_tick #(
    parameter int DIVIDER_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     arstn_i,
    input  logic                     clear_i,
    input  logic [DIVIDER_WIDTH-1:0] divider_i,
    output logic                     tick_o
);

    logic [DIVIDER_WIDTH-1:0] count_q, count_d;
    logic                     wrap;

    // Divider values 0 and 1 both collapse to a tick on every cycle.
    assign wrap   = (divider_i <= DIVIDER_WIDTH'(1)) ||
                    (count_q >= divider_i - DIVIDER_WIDTH'(1));
    assign tick_o = !clear_i && wrap;

    always_comb begin
        count_d = count_q + DIVIDER_WIDTH'(1);
        if (clear_i || wrap) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime frame format, 3-sample majority voting, error
// reporting and a ready/valid character stream with overrun detection.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int MAX_DATA_WIDTH = 9,
    parameter int OVERSAMPLE     = 16,
    parameter int DIVIDER_WIDTH  = 32
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,
    input  logic                      rx_i,
    input  logic                      en_i,
    input  logic [DIVIDER_WIDTH-1:0]  clk_divider_i,
    input  logic [3:0]                data_bits_i,
    input  logic [1:0]                parity_mode_i,
    input  logic                      stop_bits_i,
    output logic [MAX_DATA_WIDTH-1:0] m_tdata_o,
    output logic [2:0]                m_tuser_o,
    output logic                      m_tvalid_o,
    input  logic                      m_tready_i,
    output logic                      overrun_o,
    output logic                      busy_o
);

    localparam int             TW       = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  TICK_LO  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  TICK_MID = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0]  TICK_HI  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0]  TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]     MIN_BITS = 4'(UART_MIN_DATA_WIDTH);
    localparam logic [3:0]     MAX_BITS = 4'(MAX_DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2
    } rx_state_e;

    rx_state_e                 state_q, state_d;
    logic                      rx_meta_q, rx_sync_q;
    logic [TW-1:0]             tick_cnt_q, tick_cnt_d;
    logic [1:0]                samp_q, samp_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [MAX_DATA_WIDTH-1:0] data_q, data_d;
    uart_rx_cfg_t              cfg_q, cfg_d;
    logic                      par_bit_q, par_bit_d;
    logic                      par_err_q, par_err_d;
    logic                      frm_err_q, frm_err_d;
    logic [MAX_DATA_WIDTH-1:0] tdata_q, tdata_d;
    uart_rx_err_t              tuser_q, tuser_d;
    logic                      tvalid_q, tvalid_d;
    logic                      overrun_q, overrun_d;

    logic                      tick, vote, vote_tick, end_tick;
    logic                      done, final_frame;
    uart_rx_err_t              done_err;

    uart_baud_tick #(
        .DIVIDER_WIDTH(DIVIDER_WIDTH)
    ) u_baud (
        .clk_i    (clk_i),
        .arstn_i  (arstn_i),
        .clear_i  (state_q == IDLE),
        .divider_i(clk_divider_i),
        .tick_o   (tick)
    );

    assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) |
                       (samp_q[1] & rx_sync_q);
    assign vote_tick = tick && (tick_cnt_q == TICK_HI);
    assign end_tick  = tick && (tick_cnt_q == TICK_END);

    assign final_frame = frm_err_q | ~vote;
    assign done_err    = '{brk:        (data_q == '0) && !par_bit_q && final_frame,
                           frame_err:  final_frame,
                           parity_err: par_err_q};

    // Per-bit tick position and the two early majority samples; the third
    // sample is the live synchronised line at the vote tick.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        samp_d     = samp_q;
        if (state_q == IDLE) begin
            tick_cnt_d = '0;
        end else if (tick) begin
            tick_cnt_d = (tick_cnt_q == TICK_END) ? '0 : tick_cnt_q + TW'(1);
            if (tick_cnt_q == TICK_LO)  samp_d[0] = rx_sync_q;
            if (tick_cnt_q == TICK_MID) samp_d[1] = rx_sync_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        cfg_d     = cfg_q;
        par_bit_d = par_bit_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        done      = 1'b0;

        if (state_q != IDLE && !en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_i && !rx_sync_q) begin
                        state_d   = START;
                        bit_cnt_d = '0;
                        data_d    = '0;
                        par_bit_d = 1'b0;
                        par_err_d = 1'b0;
                        frm_err_d = 1'b0;
                        if (data_bits_i < MIN_BITS)      cfg_d.data_bits = MIN_BITS;
                        else if (data_bits_i > MAX_BITS) cfg_d.data_bits = MAX_BITS;
                        else                             cfg_d.data_bits = data_bits_i;
                        case (parity_mode_i)
                            2'd1:    cfg_d.parity_mode = UART_PARITY_ODD;
                            2'd2:    cfg_d.parity_mode = UART_PARITY_EVEN;
                            default: cfg_d.parity_mode = UART_PARITY_NONE;
                        endcase
                        cfg_d.stop_bits = stop_bits_i;
                    end
                end
                START: begin
                    if (vote_tick && vote)  state_d = IDLE;
                    else if (end_tick)      state_d = DATA;
                end
                DATA: begin
                    if (vote_tick) begin
                        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
                            if (bit_cnt_q == 4'(i)) data_d[i] = vote;
                        end
                    end
                    if (end_tick) begin
                        if (bit_cnt_q == cfg_q.data_bits - 4'd1) begin
                            state_d = (cfg_q.parity_mode == UART_PARITY_NONE) ? STOP1 : PARITY;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (vote_tick) begin
                        par_bit_d = vote;
                        par_err_d = vote != uart_parity(UART_MAX_DATA_WIDTH'(data_q),
                                                        cfg_q.parity_mode);
                    end
                    if (end_tick) state_d = STOP1;
                end
                // Single-stop frames finish mid-bit so a following start edge is never missed.
                STOP1: begin
                    if (vote_tick) begin
                        frm_err_d = final_frame;
                        if (!cfg_q.stop_bits) begin
                            done    = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    if (end_tick) state_d = STOP2;
                end
                STOP2: begin
                    if (vote_tick) begin
                        frm_err_d = final_frame;
                        done      = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output stream: a completed character is only accepted when the slot is
    // free or being drained this cycle; otherwise it is dropped and flagged.
    always_comb begin
        tdata_d   = tdata_q;
        tuser_d   = tuser_q;
        tvalid_d  = tvalid_q;
        overrun_d = 1'b0;
        if (tvalid_q && m_tready_i) begin
            tvalid_d = 1'b0;
        end
        if (done) begin
            if (!tvalid_q || m_tready_i) begin
                tvalid_d = 1'b1;
                tdata_d  = data_q;
                tuser_d  = done_err;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            tick_cnt_q <= '0;
            samp_q     <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            cfg_q      <= '0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            tdata_q    <= '0;
            tuser_q    <= '0;
            tvalid_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            tick_cnt_q <= tick_cnt_d;
            samp_q     <= samp_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            cfg_q      <= cfg_d;
            par_bit_q  <= par_bit_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            tdata_q    <= tdata_d;
            tuser_q    <= tuser_d;
            tvalid_q   <= tvalid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign m_tdata_o  = tdata_q;
    assign m_tuser_o  = tuser_q;
    assign m_tvalid_o = tvalid_q;
    assign overrun_o  = overrun_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Next-generation UART receiver with a runtime-configurable frame format.
- Data length, parity mode, stop-bit count and baud divider are set at runtime.
- Start-bit validation and 3-sample majority voting on every bit.
- Reports parity, framing and break errors.
- Delivers each received character on a ready/valid stream with overrun detection.
- Sits between the pad-side rx line and the register-mapped UART core, which feeds its config from the control and clk_divider registers.

Parameters:
- MAX_DATA_WIDTH, 9, widest supported character; legal range 5..9.
- OVERSAMPLE, 16, baud ticks per bit; must be even and >= 8.
- DIVIDER_WIDTH, 32, width of the baud divider input.

Ports:
- clk_i  in  1  system clock
- arstn_i  in  1  asynchronous active-low reset
- rx_i  in  1  serial line, asynchronous, idle high
- en_i  in  1  receiver enable
- clk_divider_i  in  DIVIDER_WIDTH  clk cycles per oversample tick
- data_bits_i  in  4  data bits per frame, 5..MAX_DATA_WIDTH
- parity_mode_i  in  2  parity mode: 0 none, 1 odd, 2 even, 3 reserved (treated as none)
- stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits
- m_tdata_o  out  MAX_DATA_WIDTH  received character, zero-extended
- m_tuser_o  out  3  {break, frame_err, parity_err}
- m_tvalid_o  out  1  character valid
- m_tready_i  in  1  consumer ready
- overrun_o  out  1  one-cycle pulse when a character is dropped
- busy_o  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async assert, sync release):
  - FSM enters IDLE; all counters clear.
  - Two-flop rx synchroniser resets to 1.
  - m_tdata_o, m_tuser_o, m_tvalid_o, overrun_o and busy_o reset to 0.
- Baud tick:
  - Counter pulses tick one cycle when count == clk_divider_i-1, then wraps to 0.
  - Divider values 0 and 1 give a tick every cycle.
  - Counter is held at 0 in IDLE and restarts on start detection, so sampling is phase-aligned to the falling edge.
- Config latching:
  - data_bits_i, parity_mode_i and stop_bits_i are latched at start detection.
  - Changes mid-frame have no effect on the current frame.
  - data_bits_i below 5 is treated as 5; above MAX_DATA_WIDTH it is clamped to MAX_DATA_WIDTH.
- Sampling:
  - Within each bit, the ticks are counted 0..OVERSAMPLE-1.
  - The bit value is the majority of the synchronised samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: if en_i=1 and synchronised rx=0, go to START.
  - START: at the voted mid-bit, a value of 1 is a false start: return to IDLE with no output and no error. Otherwise go to DATA at tick OVERSAMPLE-1.
  - DATA: shift bits in LSB first. After data_bits bits, go to PARITY if parity is enabled, else STOP1.
  - PARITY: compare the received bit to the expected parity. Odd mode: expected = ~^data. Even mode: expected = ^data. A mismatch sets parity_err.
  - STOP1: a voted 0 sets frame_err.
    - With one stop bit, the frame completes at the vote tick (mid-bit, not end of bit) to allow resync on back-to-back frames.
    - With two stop bits, go to STOP2 at tick OVERSAMPLE-1.
  - STOP2: same check and same mid-bit completion as STOP1.
  - break = data all zero AND parity bit (if present) zero AND frame_err.
- Output:
  - On frame completion with m_tvalid_o=0 or a handshake in the same cycle, the next cycle shows tvalid=1, tdata=data and tuser=errors.
  - tvalid holds, with data stable, until tvalid & tready.
  - If completion occurs while tvalid=1 and tready=0: the new character is dropped, the old one is kept, and overrun_o pulses for one cycle.
- Disable: en_i falling mid-frame aborts to IDLE on the next cycle. No output and no error are produced. A pending character stays valid.

Decomposition:
- uart_pkg additions:
  - uart_parity_e enum (NONE, ODD, EVEN).
  - uart_rx_cfg_t struct {data_bits, parity_mode, stop_bits}.
  - uart_rx_err_t struct {brk, frame_err, parity_err}.
  - Localparams UART_MIN_DATA_WIDTH=5 and UART_MAX_DATA_WIDTH=9.
  - A width-generic parity function.
- Sub-module uart_baud_tick: divider counter with sync clear and tick output. Reused by the future TX.

Test Plan:
- divider=1, 8N1, send 0xA5 -> tvalid 1 cycle after stop mid-sample, tdata=0x0A5, tuser=000.
- 7 bits, even parity, send 0x55 with a wrong parity bit -> tdata=0x055, tuser=001.
- 9 bits, odd parity, 2 stop, send 0x1C3 with stop2=0 -> tdata=0x1C3, tuser=010.
- Line held low for a full frame, 8N1 -> tdata=0, tuser=110 (break+frame).
- Two frames, tready=0 -> first held, overrun_o one pulse, tdata still first; then tready=1 -> handshake, tvalid=0.
- 3-tick low glitch on rx -> no tvalid, busy_o returns to 0. Separately, assert arstn_i mid-DATA -> all outputs 0, next frame received correctly.
